// File: rtl/conv3x3_window_stream.sv
// 3x3 sliding-window generator: raster pixel stream in, per-channel 3x3 windows out,
// with stride 1 or 2 latched at the first pixel of each frame.
module conv3x3_window_stream #(
  parameter int IMG_W      = 220,
  parameter int IMG_H      = 220,
  parameter int CH         = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stride_sel,
  input  logic                         valid_in,
  input  logic [CH*DATA_WIDTH-1:0]     pxl_in,
  output logic [CH*9*DATA_WIDTH-1:0]   win_out,
  output logic                         valid_out,
  output logic [$clog2(IMG_H)-1:0]     out_row,
  output logic [$clog2(IMG_W)-1:0]     out_col,
  output logic                         frame_last
);

  localparam int CW       = $clog2(IMG_W);
  localparam int RW       = $clog2(IMG_H);
  localparam int DW       = DATA_WIDTH;
  localparam int PW       = CH * DW;
  localparam int WW       = 9 * PW;
  localparam int ROW_MAX1 = IMG_H - 3;
  localparam int ROW_MAX2 = (IMG_H - 3) / 2;
  localparam int COL_MAX1 = IMG_W - 3;
  localparam int COL_MAX2 = (IMG_W - 3) / 2;

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic          stride_r;   // 0 = stride 1, 1 = stride 2

  logic [PW-1:0] lb_near_r [IMG_W];   // image row - 1
  logic [PW-1:0] lb_far_r  [IMG_W];   // image row - 2
  logic [WW-1:0] win_r;

  logic          last_col_s;
  logic          last_row_s;
  logic          frame_start_s;
  logic          stride_s;
  logic [RW-1:0] rel_row_s;
  logic [CW-1:0] rel_col_s;
  logic          in_range_s;
  logic          emit_s;
  logic [RW-1:0] orow_s;
  logic [CW-1:0] ocol_s;
  logic          flast_s;
  logic [PW-1:0] far_s;
  logic [PW-1:0] near_s;
  logic [WW-1:0] win_nxt_s;

  // Position decode, effective stride and window-emit decision for the current pixel
  always_comb begin
    last_col_s    = (col_r == CW'(IMG_W - 1));
    last_row_s    = (row_r == RW'(IMG_H - 1));
    frame_start_s = (col_r == {CW{1'b0}}) && (row_r == {RW{1'b0}});
    stride_s      = stride_r;
    if (frame_start_s) begin
      stride_s = stride_sel;
    end else begin
      stride_s = stride_r;
    end
    rel_row_s  = row_r - RW'(2);
    rel_col_s  = col_r - CW'(2);
    in_range_s = (row_r >= RW'(2)) && (col_r >= CW'(2));
    emit_s     = 1'b0;
    if (valid_in && in_range_s) begin
      emit_s = (!stride_s) || (!rel_row_s[0] && !rel_col_s[0]);
    end else begin
      emit_s = 1'b0;
    end
    orow_s  = rel_row_s;
    ocol_s  = rel_col_s;
    flast_s = 1'b0;
    if (stride_s) begin
      orow_s  = {1'b0, rel_row_s[RW-1:1]};
      ocol_s  = {1'b0, rel_col_s[CW-1:1]};
      flast_s = (orow_s == RW'(ROW_MAX2)) && (ocol_s == CW'(COL_MAX2));
    end else begin
      orow_s  = rel_row_s;
      ocol_s  = rel_col_s;
      flast_s = (orow_s == RW'(ROW_MAX1)) && (ocol_s == CW'(COL_MAX1));
    end
  end

  // Next window: every row shifts left one tap; the new right column is far/near/incoming pixel
  always_comb begin
    far_s     = lb_far_r[col_r];
    near_s    = lb_near_r[col_r];
    win_nxt_s = win_r;
    for (int c = 0; c < CH; c++) begin
      for (int r = 0; r < 3; r++) begin
        win_nxt_s[(c*9 + r*3 + 0)*DW +: DW] = win_r[(c*9 + r*3 + 1)*DW +: DW];
        win_nxt_s[(c*9 + r*3 + 1)*DW +: DW] = win_r[(c*9 + r*3 + 2)*DW +: DW];
      end
      win_nxt_s[(c*9 + 2)*DW +: DW] = far_s[c*DW +: DW];
      win_nxt_s[(c*9 + 5)*DW +: DW] = near_s[c*DW +: DW];
      win_nxt_s[(c*9 + 8)*DW +: DW] = pxl_in[c*DW +: DW];
    end
  end

  // Line buffers and shift window; contents are never cleared since emission is gated by position
  always_ff @(posedge clk) begin
    if (!reset && valid_in) begin
      lb_far_r[col_r]  <= lb_near_r[col_r];
      lb_near_r[col_r] <= pxl_in;
      win_r            <= win_nxt_s;
    end
  end

  // Raster counters, stride latch and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      col_r      <= {CW{1'b0}};
      row_r      <= {RW{1'b0}};
      stride_r   <= 1'b0;
      valid_out  <= 1'b0;
      frame_last <= 1'b0;
      out_row    <= {RW{1'b0}};
      out_col    <= {CW{1'b0}};
      win_out    <= {WW{1'b0}};
    end else begin
      valid_out  <= emit_s;
      frame_last <= emit_s && flast_s;
      if (valid_in) begin
        stride_r <= stride_s;
        if (last_col_s) begin
          col_r <= {CW{1'b0}};
          if (last_row_s) begin
            row_r <= {RW{1'b0}};
          end else begin
            row_r <= row_r + RW'(1);
          end
        end else begin
          col_r <= col_r + CW'(1);
        end
      end
      if (emit_s) begin
        win_out <= win_nxt_s;
        out_row <= orow_s;
        out_col <= ocol_s;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_window_stream.sv
// Self-checking bench for conv3x3_window_stream: 5x5 and 6x5 images, 2 channels, 8-bit pixels,
// expected windows computed directly from the image array.
module tb_conv3x3_window_stream;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int W6 = 6;
  localparam int CH = 2;
  localparam int DW = 8;
  localparam int WW = CH * 9 * DW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stride_sel = 1'b0;
  logic            valid_in = 1'b0;
  logic            valid_in6 = 1'b0;
  logic [CH*DW-1:0] pxl_in = '0;
  logic [CH*DW-1:0] pxl_in6 = '0;
  logic [WW-1:0]   win_out, win_out6;
  logic            valid_out, valid_out6, frame_last, frame_last6;
  logic [2:0]      out_row, out_col, out_row6, out_col6;

  typedef struct {
    int            r;
    int            c;
    logic [WW-1:0] w;
    logic          l;
    int            cyc;
  } rec_t;

  rec_t cap_q[$];
  rec_t cap6_q[$];
  rec_t exp_q[$];
  logic [7:0] img [0:4][0:5][0:CH-1];
  int   acc_cyc [0:29];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   idle_viol = 0;
  logic vin_prev = 1'b0;
  logic vin6_prev = 1'b0;

  conv3x3_window_stream #(.IMG_W(W), .IMG_H(H), .CH(CH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .stride_sel(stride_sel), .valid_in(valid_in), .pxl_in(pxl_in),
    .win_out(win_out), .valid_out(valid_out), .out_row(out_row), .out_col(out_col),
    .frame_last(frame_last));

  conv3x3_window_stream #(.IMG_W(W6), .IMG_H(H), .CH(CH), .DATA_WIDTH(DW)) dut6 (
    .clk(clk), .reset(reset), .stride_sel(stride_sel), .valid_in(valid_in6), .pxl_in(pxl_in6),
    .win_out(win_out6), .valid_out(valid_out6), .out_row(out_row6), .out_col(out_col6),
    .frame_last(frame_last6));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    vin_prev  <= valid_in;
    vin6_prev <= valid_in6;
  end

  // Passive capture of every emitted window; comparisons happen in the test tasks
  always @(negedge clk) begin
    if (valid_out === 1'b1) cap_q.push_back('{int'(out_row), int'(out_col), win_out, frame_last, cyc});
    if (valid_out6 === 1'b1) cap6_q.push_back('{int'(out_row6), int'(out_col6), win_out6, frame_last6, cyc});
    if ((valid_out === 1'b1 && !vin_prev) || (valid_out6 === 1'b1 && !vin6_prev)) idle_viol <= idle_viol + 1;
  end

  task automatic fill(input int mode);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 6; c++)
        for (int ch = 0; ch < CH; ch++)
          case (mode)
            0:       img[r][c][ch] = 8'(r * 5 + c + 100 * ch);
            1:       img[r][c][ch] = 8'($urandom_range(0, 254));
            default: img[r][c][ch] = 8'hFF;
          endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in  = 1'b0;
      valid_in6 = 1'b0;
    end
  endtask

  task automatic drive_frame(input int w, input int npix, input bit six, input bit s0,
                             input int tog, input bit s1, input bit gap);
    logic [CH*DW-1:0] p;
    for (int i = 0; i < npix; i++) begin
      if (gap && i == 15) idle(10);
      if (gap && i > 0) idle(1);
      @(negedge clk);
      stride_sel = (i >= tog) ? s1 : s0;
      for (int ch = 0; ch < CH; ch++) p[ch*DW +: DW] = img[i / w][i % w][ch];
      if (six) begin
        valid_in6 = 1'b1;
        pxl_in6   = p;
      end else begin
        valid_in = 1'b1;
        pxl_in   = p;
      end
      acc_cyc[i] = cyc;
    end
  endtask

  // Reference: every position satisfying the stride rule yields the 3x3 block ending there
  task automatic build_exp(input int w, input int h, input int s);
    rec_t e;
    e.cyc = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (r >= 2 && c >= 2 && (r - 2) % s == 0 && (c - 2) % s == 0) begin
          e.r = (r - 2) / s;
          e.c = (c - 2) / s;
          e.l = (e.r == (h - 3) / s) && (e.c == (w - 3) / s);
          for (int ch = 0; ch < CH; ch++)
            for (int k = 0; k < 9; k++)
              e.w[(ch*9 + k)*DW +: DW] = img[r - 2 + k / 3][c - 2 + k % 3][ch];
          exp_q.push_back(e);
        end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    n_vec++;
    if (valid_out !== 1'b0 || frame_last !== 1'b0 || win_out !== '0 || out_row !== 3'd0 || out_col !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state got v=%b l=%b r=%0d c=%0d w=%h want all zero", valid_out, frame_last, out_row, out_col, win_out);
    end
    n_vec++;
    if (valid_out6 !== 1'b0 || win_out6 !== '0) begin
      n_err++;
      $display("FAIL reset_state6 got v=%b w=%h want zero", valid_out6, win_out6);
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_stride1();
    int t0[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int t1[9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    int nl = 0;
    cap_q.delete(); exp_q.delete();
    fill(0); build_exp(W, H, 1);
    drive_frame(W, W*H, 1'b0, 1'b0, 99, 1'b0, 1'b0);
    idle(3);
    n_vec++;
    if (cap_q.size() !== exp_q.size()) begin n_err++; $display("FAIL s1_count got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (cap_q[i].r !== exp_q[i].r || cap_q[i].c !== exp_q[i].c || cap_q[i].l !== exp_q[i].l || cap_q[i].w !== exp_q[i].w) begin
        n_err++;
        $display("FAIL s1_win%0d got (%0d,%0d) l=%b %h want (%0d,%0d) l=%b %h", i, cap_q[i].r, cap_q[i].c, cap_q[i].l, cap_q[i].w, exp_q[i].r, exp_q[i].c, exp_q[i].l, exp_q[i].w);
      end
    end
    n_vec++;
    if (cap_q.size() == 0 || cap_q[0].cyc !== acc_cyc[12] + 1) begin
      n_err++; $display("FAIL s1_latency got cycle %0d want %0d", (cap_q.size() > 0) ? cap_q[0].cyc : -1, acc_cyc[12] + 1);
    end
    for (int k = 0; k < 9; k++) begin
      n_vec++;
      if (cap_q.size() < 9 || cap_q[0].w[k*DW +: DW] !== 8'(t0[k]) || cap_q[0].w[(9+k)*DW +: DW] !== 8'(t0[k] + 100)
          || cap_q[8].w[k*DW +: DW] !== 8'(t1[k])) begin
        n_err++; $display("FAIL s1_taps k=%0d got windows %0d want first %0d last %0d", k, cap_q.size(), t0[k], t1[k]);
      end
    end
    foreach (cap_q[i]) if (cap_q[i].l === 1'b1) nl++;
    n_vec++;
    if (nl !== 1 || cap_q.size() < 9 || cap_q[8].l !== 1'b1) begin n_err++; $display("FAIL s1_frame_last got %0d pulses want 1 on window 8", nl); end
    n_vec++;
    if (valid_out !== 1'b0 || win_out !== exp_q[8].w) begin n_err++; $display("FAIL s1_hold got v=%b w=%h want v=0 w=%h", valid_out, win_out, exp_q[8].w); end
  endtask

  task automatic test_stride2();
    int t1[9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    cap_q.delete(); exp_q.delete();
    fill(0); build_exp(W, H, 2);
    drive_frame(W, W*H, 1'b0, 1'b1, 99, 1'b1, 1'b0);
    idle(3);
    n_vec++;
    if (cap_q.size() !== 4) begin n_err++; $display("FAIL s2_count got %0d want 4", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (cap_q[i].r !== exp_q[i].r || cap_q[i].c !== exp_q[i].c || cap_q[i].l !== exp_q[i].l || cap_q[i].w !== exp_q[i].w) begin
        n_err++;
        $display("FAIL s2_win%0d got (%0d,%0d) l=%b %h want (%0d,%0d) l=%b %h", i, cap_q[i].r, cap_q[i].c, cap_q[i].l, cap_q[i].w, exp_q[i].r, exp_q[i].c, exp_q[i].l, exp_q[i].w);
      end
    end
    for (int k = 0; k < 9; k++) begin
      n_vec++;
      if (cap_q.size() < 4 || cap_q[3].w[k*DW +: DW] !== 8'(t1[k]) || cap_q[3].l !== 1'b1) begin
        n_err++; $display("FAIL s2_last_taps k=%0d got windows %0d want tap %0d with frame_last", k, cap_q.size(), t1[k]);
      end
    end
  endtask

  task automatic test_w6_stride2();
    cap6_q.delete(); exp_q.delete();
    fill(1); build_exp(W6, H, 2);
    drive_frame(W6, W6*H, 1'b1, 1'b1, 99, 1'b1, 1'b0);
    idle(3);
    n_vec++;
    if (cap6_q.size() !== 4) begin n_err++; $display("FAIL w6_count got %0d want 4", cap6_q.size()); end
    for (int i = 0; i < cap6_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (cap6_q[i].r !== exp_q[i].r || cap6_q[i].c !== exp_q[i].c || cap6_q[i].l !== exp_q[i].l || cap6_q[i].w !== exp_q[i].w) begin
        n_err++;
        $display("FAIL w6_win%0d got (%0d,%0d) l=%b %h want (%0d,%0d) l=%b %h", i, cap6_q[i].r, cap6_q[i].c, cap6_q[i].l, cap6_q[i].w, exp_q[i].r, exp_q[i].c, exp_q[i].l, exp_q[i].w);
      end
    end
  endtask

  task automatic test_gapped();
    cap_q.delete(); exp_q.delete();
    fill(1); build_exp(W, H, 1);
    drive_frame(W, W*H, 1'b0, 1'b0, 99, 1'b0, 1'b1);
    idle(3);
    n_vec++;
    if (cap_q.size() !== 9) begin n_err++; $display("FAIL gap_count got %0d want 9", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (cap_q[i].r !== exp_q[i].r || cap_q[i].c !== exp_q[i].c || cap_q[i].l !== exp_q[i].l || cap_q[i].w !== exp_q[i].w) begin
        n_err++;
        $display("FAIL gap_win%0d got (%0d,%0d) l=%b %h want (%0d,%0d) l=%b %h", i, cap_q[i].r, cap_q[i].c, cap_q[i].l, cap_q[i].w, exp_q[i].r, exp_q[i].c, exp_q[i].l, exp_q[i].w);
      end
    end
    n_vec++;
    if (idle_viol !== 0) begin n_err++; $display("FAIL gap_idle_valid got %0d pulses during idle want 0", idle_viol); end
  endtask

  task automatic test_back_to_back();
    int last_a;
    cap_q.delete(); exp_q.delete();
    fill(1); build_exp(W, H, 2);
    drive_frame(W, W*H, 1'b0, 1'b1, 7, 1'b0, 1'b0);
    last_a = acc_cyc[24];
    fill(1); build_exp(W, H, 1);
    drive_frame(W, W*H, 1'b0, 1'b0, 99, 1'b0, 1'b0);
    idle(3);
    n_vec++;
    if (cap_q.size() !== 13) begin n_err++; $display("FAIL b2b_count got %0d want 13", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (cap_q[i].r !== exp_q[i].r || cap_q[i].c !== exp_q[i].c || cap_q[i].l !== exp_q[i].l || cap_q[i].w !== exp_q[i].w) begin
        n_err++;
        $display("FAIL b2b_win%0d got (%0d,%0d) l=%b %h want (%0d,%0d) l=%b %h", i, cap_q[i].r, cap_q[i].c, cap_q[i].l, cap_q[i].w, exp_q[i].r, exp_q[i].c, exp_q[i].l, exp_q[i].w);
      end
    end
    n_vec++;
    if (cap_q.size() < 13 || cap_q[3].cyc !== last_a + 1 || cap_q[4].cyc !== acc_cyc[12] + 1) begin
      n_err++; $display("FAIL b2b_timing got %0d windows want frame_last at %0d and next first window at %0d", cap_q.size(), last_a + 1, acc_cyc[12] + 1);
    end
  endtask

  task automatic test_reset_midframe();
    cap_q.delete(); exp_q.delete();
    fill(2);
    drive_frame(W, 14, 1'b0, 1'b0, 99, 1'b0, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    n_vec++;
    if (valid_out !== 1'b0 || out_row !== 3'd0 || out_col !== 3'd0 || frame_last !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_state got v=%b r=%0d c=%0d l=%b want 0 0 0 0", valid_out, out_row, out_col, frame_last);
    end
    reset = 1'b0;
    idle(1);
    cap_q.delete();
    fill(1); build_exp(W, H, 1);
    drive_frame(W, W*H, 1'b0, 1'b0, 99, 1'b0, 1'b0);
    idle(3);
    n_vec++;
    if (cap_q.size() !== 9) begin n_err++; $display("FAIL rst_mid_count got %0d want 9", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (cap_q[i].r !== exp_q[i].r || cap_q[i].c !== exp_q[i].c || cap_q[i].l !== exp_q[i].l || cap_q[i].w !== exp_q[i].w) begin
        n_err++;
        $display("FAIL rst_mid_win%0d got (%0d,%0d) l=%b %h want (%0d,%0d) l=%b %h", i, cap_q[i].r, cap_q[i].c, cap_q[i].l, cap_q[i].w, exp_q[i].r, exp_q[i].c, exp_q[i].l, exp_q[i].w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stride1();
    test_stride2();
    test_w6_stride2();
    test_gapped();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv3x3_window_stream.md
# conv3x3_window_stream

Parametrised 3x3 sliding-window generator for the front end of each convolution layer, with padding 0.
- Accepts a raster-order pixel stream of CH channels and builds per-channel 3x3 windows from on-chip line buffers.
- Emits only the windows selected by a run-time stride of 1 or 2, so one block serves both the stride-2 and stride-1 stages of a layer.
- Sits between the previous layer's output stream and the per-channel MAC arrays, replacing per-channel hand-wired window logic with packed buses.

## Interface
Parameters:
- IMG_W, 220, input image width in pixels (≥3)
- IMG_H, 220, input image height in pixels (≥3)
- CH, 32, channel count (≥1)
- DATA_WIDTH, 32, bits per pixel

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- stride_sel  in  1  0 = stride 1, 1 = stride 2; sampled only at frame start
- valid_in  in  1  qualifies pxl_in; one pixel per channel per accepted cycle
- pxl_in  in  CH*DATA_WIDTH  channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- win_out  out  CH*9*DATA_WIDTH  channel c at [c*9*DATA_WIDTH +: 9*DATA_WIDTH]; tap k=r*3+q at [k*DATA_WIDTH +: DATA_WIDTH], r/q = window row/col, tap 0 = top-left (oldest), tap 8 = bottom-right (newest)
- valid_out  out  1  win_out, out_row, out_col valid
- out_row  out  $clog2(IMG_H)  output-map row index of the window
- out_col  out  $clog2(IMG_W)  output-map column index of the window
- frame_last  out  1  high with the final window of a frame

## Operation
- Input counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on valid_in. col wraps to 0 and increments row. After (IMG_H-1, IMG_W-1), both wrap to 0 for the next frame.
- Line buffers: per channel, two IMG_W-deep rows holding the previous two image rows. These are written on every accepted pixel at address col.
- The 3x3 shift window per channel shifts on every accepted pixel. No shift occurs on idle cycles.
- Stride register S is loaded from stride_sel when a pixel is accepted at (0,0). It is held for the whole frame; changes to stride_sel mid-frame are ignored.
- A window is emitted for an accepted pixel at (row, col) when all of the following hold:
  - row ≥ 2 and col ≥ 2
  - (row-2) mod S = 0
  - (col-2) mod S = 0
- For an emitted window:
  - out_row = (row-2)/S and out_col = (col-2)/S.
  - Output map size is ((IMG_H-3)/S+1) x ((IMG_W-3)/S+1), using integer division.
  - With S=2 and even IMG_W, the last image column never completes a window.
- Windows never span a row wrap. Windows at col<2 are suppressed, regardless of stale window contents.
- frame_last is asserted with the window where out_row and out_col are both at their maximum for the latched S.
- Pixel data is passed through unmodified; there is no arithmetic on data.
- Reset:
  - Outputs and state: valid_out=0, frame_last=0, win_out=0, out_row=0, out_col=0; counters=0; S=1.
  - Line buffer contents need not be cleared, because windows are gated by row/col.
  - A reset mid-frame discards the partial frame. The next accepted pixel is treated as (0,0).

## Timing
- Latency: 1 cycle. The window completed by the pixel accepted in cycle t appears with valid_out=1 in cycle t+1.
- valid_out, frame_last, out_row and out_col are registered. valid_out is a one-cycle pulse per window.
- win_out holds its last value when valid_out=0.
- There is no back-pressure; the downstream stage must accept every valid_out pulse.
- Arbitrary valid_in gaps are allowed anywhere, including across row and frame boundaries. Output is identical, apart from timing, to a gap-free stream.
- A new frame's (0,0) pixel may be accepted in the cycle right after the previous frame's last pixel. frame_last and the new frame's stride latch occur without a bubble.

## Test plan
- Stride 1:
  - Setup: IMG_W=IMG_H=5, CH=2, DATA_WIDTH=8; ch0 pixel = row*5+col, ch1 = 100+row*5+col; gap-free stream.
  - 9 windows, (0,0)..(2,2).
  - The first window arrives 1 cycle after pixel 12 is accepted, with ch0 taps 0,1,2,5,6,7,10,11,12 and ch1 taps offset by 100.
  - frame_last is high only on window (2,2), whose ch0 taps are 12,13,14,17,18,19,22,23,24.
- Stride 2, same image:
  - Exactly 4 windows, at input (2,2),(2,4),(4,2),(4,4), with out coords (0,0),(0,1),(1,0),(1,1).
  - The (1,1) window has ch0 taps 12,13,14,17,18,19,22,23,24 and frame_last=1.
  - With IMG_W=6, stride 2: input column 5 produces no windows.
- Gapped input:
  - Stride 1 stream with valid_in low every other cycle plus a 10-cycle gap at the row 3 boundary.
  - Window sequence and contents are identical to the stride-1 case, and valid_out is never set during idle.
- Stride change:
  - stride_sel=1 at (0,0), toggled to 0 at pixel 7.
  - The frame still yields 4 stride-2 windows.
  - The next frame, starting with stride_sel=0, yields 9 windows back-to-back without a bubble.
- Reset mid-frame:
  - Assert reset after pixel 13 of a 5x5 stride-1 frame.
  - Next cycle: valid_out=0, out_row=out_col=0.
  - A fresh full frame then yields exactly 9 correct windows, with no window containing pre-reset data.
